// File: rtl/lsu_pkg.sv
// Shared funct3 size/sign codes and FSM state encoding for the load/store RAM master.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for byte/half/word accesses: load extraction, store merge and
// error detection. Misalignment trapping is enabled by defining LSU_MISALIGN_CHECK_EN.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  input  logic        we_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o,
  output logic        err_o
);

  logic        is_word;
  logic        is_half;
  logic        illegal;
  logic        misalign;
  logic [1:0]  eff_off;
  logic [31:0] shifted;
  logic        unused_wdata_hi;

  assign unused_wdata_hi = ^wdata_i[31:16];

  always_comb begin
    is_word = (funct3_i[1:0] == 2'b10);
    is_half = (funct3_i[1:0] == 2'b01);
    // Stores only know B/H/W; loads additionally reject the unused unsigned-word codes.
    illegal = we_i ? (funct3_i >= 3'b011)
                   : ((funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11));
`ifdef LSU_MISALIGN_CHECK_EN
    misalign = (is_word && (offset_i != 2'b00)) || (is_half && offset_i[0]);
    eff_off  = offset_i;
`else
    misalign = 1'b0;
    eff_off  = is_word ? 2'b00 : (is_half ? {offset_i[1], 1'b0} : offset_i);
`endif
    err_o = illegal || misalign;
  end

  always_comb begin
    shifted = word_i >> {eff_off, 3'b000};
    case (funct3_i)
      F3_B:    load_data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_data_o = {24'h0, shifted[7:0]};
      F3_H:    load_data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_data_o = {16'h0, shifted[15:0]};
      default: load_data_o = word_i;
    endcase
  end

  always_comb begin
    // NOTE: every variable gets a full default before the case so no latch is inferred.
    merged_o = word_i;
    case (funct3_i)
      F3_B:    merged_o[{eff_off, 3'b000} +: 8]        = wdata_i[7:0];
      F3_H:    merged_o[{eff_off[1], 4'b0000} +: 16]   = wdata_i[15:0];
      default: merged_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_ram_master.sv
// RV32I load/store initiator for a level-written, combinational-read word RAM; sub-word stores
// use read-modify-write. Optional misalignment trapping via LSU_MISALIGN_CHECK_EN.
module lsu_ram_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [31:0]       i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [2:0]        i_funct3,
  output logic              o_ready,
  output logic              o_rvalid,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_wr,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  state_e              state_q, state_d;
  logic [1:0]          off_q, off_d;
  logic [2:0]          funct3_q, funct3_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_wr_q, mem_wr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                rvalid_q, rvalid_d;
  logic                ready_q, ready_d;

  logic                idle;
  logic [1:0]          al_off;
  logic [2:0]          al_funct3;
  logic                al_we;
  logic [DATA_W-1:0]   al_load;
  logic [DATA_W-1:0]   al_merged;
  logic                al_err;
  logic                unused_addr_hi;

  assign unused_addr_hi = ^i_addr[31:ADDR_W+2];

  // In IDLE the aligner classifies the incoming request; afterwards it works on latched fields.
  assign idle      = (state_q == ST_IDLE);
  assign al_off    = idle ? i_addr[1:0] : off_q;
  assign al_funct3 = idle ? i_funct3    : funct3_q;
  assign al_we     = idle ? i_we        : we_q;

  lsu_align u_align (
    .word_i      (i_mem_rdata),
    .wdata_i     (wdata_q),
    .offset_i    (al_off),
    .funct3_i    (al_funct3),
    .we_i        (al_we),
    .load_data_o (al_load),
    .merged_o    (al_merged),
    .err_o       (al_err)
  );

  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    funct3_d    = funct3_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    mem_wr_d    = 1'b0;
    rvalid_d    = 1'b0;
    ready_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (i_req && ready_q) begin
          ready_d    = 1'b0;
          off_d      = i_addr[1:0];
          funct3_d   = i_funct3;
          we_d       = i_we;
          wdata_d    = i_wdata;
          mem_addr_d = i_addr[ADDR_W+1:2];
          if (al_err) begin
            err_d    = 1'b1;
            rdata_d  = '0;
            rvalid_d = 1'b1;
            state_d  = ST_RESP;
          end else if (i_we && (i_funct3 == F3_W)) begin
            mem_wdata_d = i_wdata;
            mem_wr_d    = 1'b1;
            state_d     = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        if (we_q) begin
          mem_wdata_d = al_merged;
          mem_wr_d    = 1'b1;
          state_d     = ST_WR;
        end else begin
          rdata_d  = al_load;
          err_d    = 1'b0;
          rvalid_d = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_WR: begin
        rdata_d  = '0;
        err_d    = 1'b0;
        rvalid_d = 1'b1;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      off_q       <= '0;
      funct3_q    <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wr_q    <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      rvalid_q    <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      funct3_q    <= funct3_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wr_q    <= mem_wr_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      rvalid_q    <= rvalid_d;
      ready_q     <= ready_d;
    end
  end

  assign o_ready     = ready_q;
  assign o_rvalid    = rvalid_q;
  assign o_rdata     = rdata_q;
  assign o_err       = err_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_wr    = mem_wr_q;

endmodule

// File: tb/tb_lsu_ram_master.sv
// Self-checking bench for lsu_ram_master: directed plan cases, error codes, reset during RD and
// randomized traffic against a byte-lane reference model. Honours LSU_MISALIGN_CHECK_EN.
module tb_lsu_ram_master;

  localparam int ADDR_W = 13;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_req = 1'b0;
  logic              i_we = 1'b0;
  logic [31:0]       i_addr = '0;
  logic [31:0]       i_wdata = '0;
  logic [2:0]        i_funct3 = '0;
  logic              o_ready;
  logic              o_rvalid;
  logic [31:0]       o_rdata;
  logic              o_err;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [31:0]       o_mem_wdata;
  logic              o_mem_wr;
  logic [31:0]       i_mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] ram     [0:(1<<ADDR_W)-1];
  logic [31:0] ref_mem [0:(1<<ADDR_W)-1];
  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [31:0]       pl_data = '0;

  always #5 clk = ~clk;

  lsu_ram_master #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req       (i_req),
    .i_we        (i_we),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .i_funct3    (i_funct3),
    .o_ready     (o_ready),
    .o_rvalid    (o_rvalid),
    .o_rdata     (o_rdata),
    .o_err       (o_err),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_wr    (o_mem_wr),
    .i_mem_rdata (i_mem_rdata)
  );

  // Level-written RAM with combinational read, plus a bench-side preload port.
  assign i_mem_rdata = ram[o_mem_addr];
  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (o_mem_wr) ram[o_mem_addr] <= o_mem_wdata;
  end

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = idx[ADDR_W-1:0]; pl_data = val;
    @(posedge clk); #1;
    pl_en = 1'b0;
    ref_mem[idx] = val;
  endtask

  // Reference model: byte-lane arithmetic straight from the access rules.
  task automatic ref_op(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, output bit e_err, output logic [31:0] e_rd,
                        output int e_lat, output bit e_wr, output logic [31:0] e_word);
    int size, off, idx;
    logic [63:0] m;
    logic [31:0] v;
    idx  = int'(addr[ADDR_W+1:2]);
    off  = int'(addr[1:0]);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    if (we) e_err = (f3 >= 3'd3);
    else    e_err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
`ifdef LSU_MISALIGN_CHECK_EN
    if ((off % size) != 0) e_err = 1'b1;
`else
    off = off - (off % size);
`endif
    e_rd = '0; e_wr = 1'b0; e_word = '0;
    m = ((64'd1 << (8*size)) - 64'd1) << (8*off);
    if (e_err) begin
      e_lat = 1;
    end else if (!we) begin
      v = (ref_mem[idx] & m[31:0]) >> (8*off);
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~(m[31:0] >> (8*off));
      e_rd  = v;
      e_lat = 2;
    end else begin
      v      = wdata << (8*off);
      e_word = (ref_mem[idx] & ~m[31:0]) | (v & m[31:0]);
      e_wr   = 1'b1;
      e_lat  = (size == 4) ? 2 : 3;
      ref_mem[idx] = e_word;
    end
  endtask

  // Issue one request and collect completion timing, response and RAM write activity.
  task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3, output bit got, output int lat,
                       output logic [31:0] rd, output bit er, output int nwr,
                       output logic [ADDR_W-1:0] waddr, output logic [31:0] wword,
                       output bit rdy_after);
    int guard = 0;
    got = 1'b0; lat = 0; rd = '0; er = 1'b0; nwr = 0; waddr = '0; wword = '0; rdy_after = 1'b0;
    @(negedge clk);
    while (o_ready !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    i_req = 1'b1; i_we = we; i_addr = addr; i_wdata = wdata; i_funct3 = f3;
    @(posedge clk); #1;
    i_req = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (o_mem_wr === 1'b1) begin nwr++; waddr = o_mem_addr; wword = o_mem_wdata; end
      if (o_rvalid === 1'b1) begin got = 1'b1; lat = n; rd = o_rdata; er = o_err; break; end
    end
    if (got) begin @(negedge clk); rdy_after = o_ready; end
  endtask

  task automatic run_op(input string tag, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        output logic [31:0] rd, output bit er, output int lat,
                        output logic [31:0] wword);
    bit got, rdy, e_err, e_wr;
    int nwr, e_lat;
    logic [ADDR_W-1:0] waddr;
    logic [31:0] e_rd, e_word;
    ref_op(we, addr, wdata, f3, e_err, e_rd, e_lat, e_wr, e_word);
    issue(we, addr, wdata, f3, got, lat, rd, er, nwr, waddr, wword, rdy);
    n_cmp++;
    if (!got) begin
      n_bad++; $display("FAIL %s timeout: no o_rvalid within 8 cycles", tag);
    end else begin
      n_cmp += 4;
      if (lat !== e_lat) begin n_bad++; $display("FAIL %s latency: got %0d want %0d", tag, lat, e_lat); end
      if (er !== e_err) begin n_bad++; $display("FAIL %s err: got %0b want %0b", tag, er, e_err); end
      if (rd !== e_rd && (!we || e_err)) begin n_bad++; $display("FAIL %s rdata: got %h want %h", tag, rd, e_rd); end
      if (rdy !== 1'b1) begin n_bad++; $display("FAIL %s ready_after_resp: got %b want 1", tag, rdy); end
    end
    n_cmp++;
    if (nwr !== (e_wr ? 1 : 0)) begin
      n_bad++; $display("FAIL %s write_count: got %0d want %0d", tag, nwr, e_wr ? 1 : 0);
    end else if (e_wr) begin
      n_cmp += 2;
      if (waddr !== addr[ADDR_W+1:2]) begin n_bad++; $display("FAIL %s write_addr: got %h want %h", tag, waddr, addr[ADDR_W+1:2]); end
      if (wword !== e_word) begin n_bad++; $display("FAIL %s write_data: got %h want %h", tag, wword, e_word); end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp += 7;
    if (o_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    if (o_rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid: got %b want 0", o_rvalid); end
    if (o_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", o_err); end
    if (o_mem_wr !== 1'b0) begin n_bad++; $display("FAIL reset_mem_wr: got %b want 0", o_mem_wr); end
    if (o_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", o_rdata); end
    if (o_mem_addr !== '0) begin n_bad++; $display("FAIL reset_mem_addr: got %h want 0", o_mem_addr); end
    if (o_mem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_mem_wdata: got %h want 0", o_mem_wdata); end
  endtask

  task automatic test_plan();
    logic [31:0] rd, ww; bit er; int lat;
    preload(5, 32'h8899AABB);
    run_op("lb_0x15", 1'b0, 32'h15, 32'h0, 3'b000, rd, er, lat, ww);
    n_cmp++; if (rd !== 32'hFFFFFFAA) begin n_bad++; $display("FAIL plan_lb: got %h want ffffffaa", rd); end
    run_op("lhu_0x16", 1'b0, 32'h16, 32'h0, 3'b101, rd, er, lat, ww);
    n_cmp++; if (rd !== 32'h00008899) begin n_bad++; $display("FAIL plan_lhu: got %h want 00008899", rd); end
    run_op("lh_0x14", 1'b0, 32'h14, 32'h0, 3'b001, rd, er, lat, ww);
    n_cmp++; if (rd !== 32'hFFFFAABB) begin n_bad++; $display("FAIL plan_lh: got %h want ffffaabb", rd); end
    run_op("sw_0x20", 1'b1, 32'h20, 32'hDEADBEEF, 3'b010, rd, er, lat, ww);
    run_op("lw_0x20", 1'b0, 32'h20, 32'h0, 3'b010, rd, er, lat, ww);
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL plan_lw: got %h want deadbeef", rd); end
    preload(8, 32'h11223344);
    run_op("sb_0x22", 1'b1, 32'h22, 32'h000000A5, 3'b000, rd, er, lat, ww);
    n_cmp += 2;
    if (ww !== 32'h11A53344) begin n_bad++; $display("FAIL plan_sb_merge: got %h want 11a53344", ww); end
    if (lat !== 3) begin n_bad++; $display("FAIL plan_sb_latency: got %0d want 3", lat); end
    run_op("sw_0x21", 1'b1, 32'h21, 32'hCAFEF00D, 3'b010, rd, er, lat, ww);
`ifdef LSU_MISALIGN_CHECK_EN
    n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL plan_sw_misalign: got err %b want 1", er); end
`else
    n_cmp++; if (ram[8] !== 32'hCAFEF00D) begin n_bad++; $display("FAIL plan_sw_unaligned: got %h want cafef00d", ram[8]); end
`endif
  endtask

  task automatic test_errors();
    logic [31:0] rd, ww; bit er; int lat;
    for (int f = 3; f < 8; f++) begin
      run_op("store_err", 1'b1, 32'h0C, $urandom, f[2:0], rd, er, lat, ww);
      if (f == 3 || f >= 6) run_op("load_err", 1'b0, 32'h0C, 32'h0, f[2:0], rd, er, lat, ww);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, ww; bit er; int lat;
    bit seen_wr = 1'b0, seen_rv = 1'b0;
    preload(3, 32'h5A5A1234);
    @(negedge clk);
    i_req = 1'b1; i_we = 1'b1; i_addr = 32'h0E; i_wdata = 32'h0000BEEF; i_funct3 = 3'b001;
    @(posedge clk); #1;
    i_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    if (o_mem_wr === 1'b1) seen_wr = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_ready: got %b want 1", o_ready); end
    for (int n = 0; n < 4; n++) begin
      if (o_mem_wr === 1'b1) seen_wr = 1'b1;
      if (o_rvalid === 1'b1) seen_rv = 1'b1;
      @(negedge clk);
    end
    n_cmp += 3;
    if (seen_wr) begin n_bad++; $display("FAIL rst_mid_no_write: got write want none"); end
    if (seen_rv) begin n_bad++; $display("FAIL rst_mid_no_rvalid: got rvalid want none"); end
    if (ram[3] !== 32'h5A5A1234) begin n_bad++; $display("FAIL rst_mid_mem: got %h want 5a5a1234", ram[3]); end
    run_op("ld_f3_011", 1'b0, 32'h0C, 32'h0, 3'b011, rd, er, lat, ww);
    n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL rst_mid_load_err: got %b want 1", er); end
  endtask

  task automatic test_random();
    logic [31:0] rd, ww, addr; bit er; int lat;
    for (int i = 0; i < 200; i++) begin
      addr = ($urandom & 32'hFFFF8000) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      run_op("random", 1'($urandom_range(0, 1)), addr, $urandom, 3'($urandom_range(0, 7)),
             rd, er, lat, ww);
    end
    for (int w = 0; w < 16; w++) begin
      n_cmp++;
      if (ram[w] !== ref_mem[w]) begin n_bad++; $display("FAIL final_mem[%0d]: got %h want %h", w, ram[w], ref_mem[w]); end
    end
  endtask

  initial begin
    test_reset();
    for (int w = 0; w < 16; w++) preload(w, $urandom);
    test_plan();
    test_errors();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_ram_master.md
Name: lsu_ram_master

Overview:
- Load/store initiator that drives the word-addressed data RAM port: address, write data, level write strobe, combinational read data.
- Converts core byte-addressed RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-RAM cycles.
- Sub-word stores use read-modify-write.
- Sits between the execute stage and the data RAM, with a req/ready and rvalid handshake on the core side.

Parameters:
- ADDR_W, 13, RAM word-address width; byte address bits [ADDR_W+1:2] select the word, higher bits ignored (wrap).
- DATA_W, 32, RAM word width; fixed at 32, other values unsupported.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_req  in  1  core request; accepted when i_req && o_ready at posedge clk
- i_we  in  1  1=store, 0=load
- i_addr  in  32  byte address
- i_wdata  in  32  store data (low bits used for SB/SH)
- i_funct3  in  3  RV32I funct3 access size/sign
- o_ready  out  1  high only in IDLE
- o_rvalid  out  1  one-cycle completion pulse (loads and stores)
- o_rdata  out  32  load result, valid with o_rvalid
- o_err  out  1  access error, valid with o_rvalid
- o_mem_addr  out  ADDR_W  RAM word address
- o_mem_wdata  out  32  RAM write data
- o_mem_wr  out  1  RAM write strobe, level-sensitive
- i_mem_rdata  in  32  RAM combinational read data

Behaviour:
- All outputs are registered. The RAM writes on level, so o_mem_addr, o_mem_wdata and o_mem_wr come straight from flops, with no combinational path from core inputs.
- Reset values:
  - state=IDLE, o_ready=1, o_rvalid=0, o_err=0, o_mem_wr=0.
  - o_rdata=0, o_mem_addr=0, o_mem_wdata=0.
- States: IDLE, RD, WR, RESP.
- IDLE:
  - On accept, latch addr, funct3, we and wdata; set o_mem_addr=i_addr[ADDR_W+1:2].
  - Next state is RD for a load or a sub-word store, WR for SW, RESP with err=1 for an error.
- RD (one cycle):
  - Sample i_mem_rdata at the end of the cycle.
  - Load: extract and sign/zero-extend into o_rdata, go to RESP.
  - SB/SH: merge store bytes into the sampled word, place the result on o_mem_wdata, go to WR.
- WR (exactly one cycle):
  - o_mem_wr=1 with address and data stable for the whole cycle.
  - Next state RESP; o_mem_wr drops on leaving WR.
- RESP (one cycle): o_rvalid=1, o_ready=0, then IDLE.
- Latency from accept edge to the o_rvalid cycle:
  - load: 2 cycles
  - SW: 2 cycles
  - SB/SH: 3 cycles
  - error: 1 cycle
- Throughput: the next request is accepted in the cycle after RESP.
- Extraction uses byte offset a[1:0]:
  - LB/LBU: byte a[1:0].
  - LH/LHU: half a[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Merge: SB replaces byte a[1:0] with wdata[7:0]; SH replaces half a[1] with wdata[15:0]; other bytes are preserved.
- Errors (o_err=1, no RAM write, o_rdata=0):
  - load funct3 in {011,110,111};
  - store funct3 >= 011.
- Outside RESP, o_rdata and o_err hold their last values.
- Requests presented while o_ready=0 are ignored; the core holds i_req.
- Reset mid-operation: next edge returns to IDLE with o_mem_wr=0 and no o_rvalid.
  - Reset during RD leaves memory untouched.
  - Reset coincident with WR does not cancel that WR cycle's write, since the RAM is level-written during the cycle.

Optional Feature:
- Macro LSU_MISALIGN_CHECK_EN.
- Defined: LW/SW with a[1:0]!=0 and LH/LHU/SH with a[0]=1 complete as errors (o_err=1, 1-cycle latency, no write).
- Undefined: misalignment is not checked; low address bits are forced down (word: a[1:0]=0, half: a[0]=0) and the access proceeds normally.

Decomposition:
- Package lsu_pkg:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101;
  - state encoding ST_IDLE/ST_RD/ST_WR/ST_RESP (2-bit).
- One sub-module, lsu_align: purely combinational.
  - Load path: (word, offset, funct3) -> extended load data.
  - Store path: (word, wdata, offset, funct3) -> merged word.
  - Error/misalign flag.

Test Plan:
- RAM word 5 = 0x8899AABB; LB from addr 0x15 -> o_rvalid 2 cycles after accept, o_rdata=0xFFFFFFAA, o_err=0.
- Same word; LHU from addr 0x16 -> o_rdata=0x00008899; LH from addr 0x14 -> 0xFFFFAABB.
- SW 0xDEADBEEF to addr 0x20 -> one-cycle o_mem_wr with o_mem_addr=8; a later LW returns 0xDEADBEEF.
- Word 8 = 0x11223344; SB 0xA5 to addr 0x22 -> RD then WR, o_mem_wdata=0x11A53344, o_rvalid 3 cycles after accept.
- With LSU_MISALIGN_CHECK_EN: SW to addr 0x21 -> o_err=1 one cycle after accept, no o_mem_wr. Without the macro: the write lands at word 8.
- rst asserted during RD of an SH -> IDLE next edge, o_mem_wr never asserted, memory unchanged, no o_rvalid; a load funct3=011 returns o_err=1.
